// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Captures {perr, data} on each rcv pulse into a first-word-fall-through FIFO,
// hands entries to the consumer over valid/ready, and keeps a sticky overflow
// flag for bytes dropped while full.
// Optional feature macro: UART_RX_FIFO_AFULL_EN adds a registered o_afull output.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AFULL_THR = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    i_data,
   input  logic          i_rcv,
   input  logic          i_perr,
   output logic [7:0]    o_data,
   output logic          o_perr,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_overflow,
   input  logic          i_clr_ovf
`ifdef UART_RX_FIFO_AFULL_EN
   ,output logic         o_afull
`endif
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;

   assign o_full     = (count_q == FULL_CNT);
   assign o_empty    = (count_q == '0);
   assign o_valid    = ~o_empty;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;

   // Pop only ever sees a stored entry; a full FIFO may still accept a byte
   // when the head leaves in the same cycle.
   assign pop  = o_valid & i_ready;
   assign push = i_rcv & (~o_full | pop);
   assign drop = i_rcv & ~push;

   // Head outputs read storage directly, forced to zero while empty.
   always_comb begin
      o_data = 8'h00;
      o_perr = 1'b0;
      if (!o_empty) begin
         o_data = mem_q[rd_ptr_q][7:0];
         o_perr = mem_q[rd_ptr_q][8];
      end
   end

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)           ovf_d = 1'b1;
      else if (i_clr_ovf) ovf_d = 1'b0;
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is never cleared; a push coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (push && rst) mem_q[wr_ptr_q] <= {i_perr, i_data};
   end

`ifdef UART_RX_FIFO_AFULL_EN
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_THR);
   logic afull_q;

   assign o_afull = afull_q;

   // Registered alongside the count so it tracks the occupancy it reports on.
   always_ff @(posedge clk) begin
      if (!rst) afull_q <= 1'b0;
      else      afull_q <= (count_d >= AFULL_CNT);
   end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table-driven vectors for the single-entry corner
// cases plus a queue scoreboard that predicts every accepted byte and checks
// it when the consumer takes it.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    i_data = 8'h00;
   logic          i_rcv = 1'b0;
   logic          i_perr = 1'b0;
   logic          i_ready = 1'b0;
   logic          i_clr_ovf = 1'b0;
   logic [7:0]    o_data;
   logic          o_perr, o_valid, o_full, o_empty, o_overflow;
   logic [AW:0]   o_count;
`ifdef UART_RX_FIFO_AFULL_EN
   logic          o_afull;
`endif

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_THR(12)) dut (
      .clk(clk), .rst(rst),
      .i_data(i_data), .i_rcv(i_rcv), .i_perr(i_perr),
      .o_data(o_data), .o_perr(o_perr), .o_valid(o_valid), .i_ready(i_ready),
      .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
      .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
`ifdef UART_RX_FIFO_AFULL_EN
      , .o_afull(o_afull)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // scoreboard / reference model
   logic [8:0] sb[$];
   int         mcnt = 0;
   logic       movf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_empty"}, o_empty, 1);
      chk({tag, "_full"},  o_full, 0);
      chk({tag, "_data"},  o_data, 0);
      chk({tag, "_perr"},  o_perr, 0);
      chk({tag, "_count"}, o_count, 0);
      chk({tag, "_ovf"},   o_overflow, 0);
`ifdef UART_RX_FIFO_AFULL_EN
      chk({tag, "_afull"}, o_afull, 0);
`endif
   endtask

   // One clock: predict, check the head if it is taken, drive, then check state.
   task automatic cyc(input logic rcv, input logic [7:0] d, input logic pe,
                      input logic rdy, input logic clr);
      logic [8:0] h;
      bit pm, pu;
      pm = (mcnt > 0) && rdy;
      chk("valid_pre", o_valid, (mcnt > 0));
      if (pm) begin
         h = sb.pop_front();
         chk("head_data", o_data, h[7:0]);
         chk("head_perr", o_perr, h[8]);
      end
      pu = rcv && ((mcnt < DEPTH) || pm);
      if (pu) sb.push_back({pe, d});
      if (rcv && !pu) movf = 1'b1;
      else if (clr)   movf = 1'b0;
      mcnt = mcnt + int'(pu) - int'(pm);
      i_rcv = rcv; i_data = d; i_perr = pe; i_ready = rdy; i_clr_ovf = clr;
      @(posedge clk); #1;
      i_rcv = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0;
      chk("count", o_count, mcnt);
      chk("full",  o_full,  (mcnt == DEPTH));
      chk("empty", o_empty, (mcnt == 0));
      chk("ovf",   o_overflow, movf);
      if (mcnt == 0) chk("empty_data", {o_perr, o_data}, 0);
   endtask

   task automatic do_reset(input logic rcv_during);
      rst = 1'b0; i_rcv = rcv_during; i_ready = rcv_during; i_data = 8'hFF;
      @(posedge clk); #1;
      rst = 1'b1; i_rcv = 1'b0; i_ready = 1'b0;
      sb.delete(); mcnt = 0; movf = 1'b0;
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1 && mcnt > 0; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   typedef struct {
      logic       rcv;
      logic [7:0] d;
      logic       pe;
      logic       rdy;
      logic       clr;
      int         cnt;
      logic       vld;
      logic [7:0] od;
      logic       op;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [7:0] last;
      //          rcv   d      pe    rdy   clr   cnt vld   od     op
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tbl[2] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b1};
      tbl[3] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h11, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h11, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);
      check_reset_state("rst");

      // single entry corner cases
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].rcv, tbl[i].d, tbl[i].pe, tbl[i].rdy, tbl[i].clr);
         chk("tbl_cnt",  o_count, tbl[i].cnt);
         chk("tbl_vld",  o_valid, tbl[i].vld);
         chk("tbl_data", o_data,  tbl[i].od);
         chk("tbl_perr", o_perr,  tbl[i].op);
      end

      // fill to full, drain in order
      fill(8'h00);
      chk("full_flag", o_full, 1);
      chk("full_cnt",  o_count, DEPTH);
      drain();
      chk("drained", o_empty, 1);

      // overflow: drop while full, set wins over clear, then clear
      fill(8'h20);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", o_overflow, 1);
      chk("ovf_cnt", o_count, DEPTH);
      cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
      chk("ovf_setwins", o_overflow, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ovf_hold", o_overflow, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", o_overflow, 0);
      drain();

      // full with simultaneous push and pop
      fill(8'h40);
      cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      chk("fpp_cnt", o_count, DEPTH);
      chk("fpp_ovf", o_overflow, 0);
      last = 8'h00;
      while (mcnt > 0) begin
         if (mcnt == 1) last = o_data;
         cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      chk("fpp_last", last, 8'h77);

      // parity flag follows its byte
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
      chk("perr_head1", o_perr, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("perr_head0", o_perr, 0);
      chk("perr_data",  o_data, 8'h3D);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // random traffic across pointer wrap
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      drain();

`ifdef UART_RX_FIFO_AFULL_EN
      for (int i = 0; i < 11; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("afull_11", o_afull, 0);
      cyc(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
      chk("afull_12", o_afull, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("afull_pop", o_afull, 0);
`endif

      // reset in the middle of a burst, with push and ready active
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      do_reset(1'b1);
      check_reset_state("midrst");
      cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      chk("post_rst_data", o_data, 8'hC3);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
